reservation_station_add: RTL and testbench
==========================================

Name: reservation_station_add

Overview:
- Single-entry adder reservation station with an integrated ADD/SUB functional unit for the Tomasulo core.
- Accepts one issued instruction and holds operand values or producer tags.
- Snoops the Common Data Bus (Qi_CDB/Qi_CDB_data) to resolve pending operands, then executes.
- Raises Done with the result Q and holds both until its own tag is seen broadcast on the CDB. It is the producer/consumer counterpart of the CDB arbiter.

Parameters:
- STATION_ID, 3'd1: own tag; 1 = ADD1, 2 = ADD2; 0 is reserved (FREE_REGISTER = no producer).
- EXEC_LATENCY, 2: cycles from entering EXEC to Done; legal range 1..15.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset (Reset=0 resets).
- Issue_Valid  input  1  issue request; accepted only when Busy=0.
- Issue_Op  input  1  0 = Vj+Vk, 1 = Vj-Vk.
- Issue_Vj  input  16  operand j value; meaningful when Issue_Qj=0.
- Issue_Qj  input  3  producer tag for j; 0 = value ready.
- Issue_Vk  input  16  operand k value.
- Issue_Qk  input  3  producer tag for k.
- CDB_Valid  input  1  qualifies Qi_CDB/Qi_CDB_data this cycle.
- Qi_CDB  input  3  broadcasting station tag.
- Qi_CDB_data  input  16  broadcast result.
- Busy  output  1  entry occupied.
- Done  output  1  result ready, waiting for CDB grant (feeds Done_ADDx).
- Q  output  16  result (feeds Q_ADDx).

Behaviour:
- Reset=0, asynchronous: Busy=0, Done=0, Q=0; state FREE; Vj, Vk, Qj, Qk, Op, and the latency counter all cleared. This applies in any state; an in-flight instruction is discarded.
- "CDB hit on tag T" means CDB_Valid=1, Qi_CDB=T and T!=0.

State FREE:
- If Issue_Valid=1, capture Op/Vj/Qj/Vk/Qk on the edge and set Busy=1.
- Same-cycle bypass: if the CDB hits on Issue_Qj, store Vj=Qi_CDB_data and Qj=0. Same rule for k.
- Next state is EXEC if both resulting Q tags are 0, else WAIT_OPS.

State WAIT_OPS:
- Each edge, independently for j and k: on a CDB hit on the stored Qj, set Vj=Qi_CDB_data and Qj=0 (likewise for k).
- If Qj=Qk and that tag hits, both operands resolve on the same edge.
- Go to EXEC on the edge where both tags become 0.

State EXEC:
- The counter loads EXEC_LATENCY-1 on entry and decrements each edge.
- On the edge where it reads 0: Q = Vj±Vk modulo 2^16 (wrap, no carry/borrow output), Done=1, go to WRITEBACK.
- Net effect: Done rises exactly EXEC_LATENCY edges after the EXEC-entry edge.

State WRITEBACK:
- Done and Q are held stable.
- On a CDB hit on STATION_ID: Done=0, Busy=0, go to FREE. Q keeps its last value.
- A CDB hit on another tag has no effect.

Other rules:
- Issue_Valid while Busy=1 is ignored; no state change.
- Issue_Valid in FREE is accepted even on the edge after a free; the earliest is the edge following Busy=0.
- CDB snooping is ignored in FREE (except the issue bypass), EXEC and WRITEBACK.
- A stored tag equal to STATION_ID is illegal at issue; behaviour is undefined, and the bench asserts it never occurs.

Test Plan:
- Ready issue: Issue_Valid=1, Op=0, Vj=16'd5, Vk=16'd7, Qj=Qk=0, EXEC_LATENCY=2 → Busy=1 after edge 0; Done=1, Q=16'd12 after edge 2. Grant (CDB_Valid=1, Qi_CDB=1) at edge 4 → Busy=0, Done=0 after edge 4.
- Pending operand: issue Qj=2, Vk=16'd3, Op=1 → stays WAIT_OPS, Done=0. CDB hit Qi_CDB=2, data=16'd10 → EXEC next edge; Done with Q=16'd7 after EXEC_LATENCY more edges.
- Wrap/bypass: issue Op=1, Vj=0, Qk=2 while the CDB is hitting tag 2 with data=16'd1 → goes straight to EXEC; Q=16'hFFFF.
- Both operands on one tag: Qj=Qk=2, CDB hit 2 with data=16'h8000, Op=0 → Q=16'h0000; foreign tag 3 broadcast beforehand is ignored.
- Busy and foreign grant: second Issue_Valid during WAIT_OPS is ignored (operands unchanged). In WRITEBACK, CDB hit on tag 2 while STATION_ID=1 → Done stays 1 and Q is held.
- Reset mid-op: drive Reset=0 asynchronously (between edges) during EXEC → Busy, Done and Q are 0 immediately. After Reset=1, a new issue completes normally.

Source files
------------

// File: rtl/reservation_station_add.sv
// Single-entry ADD/SUB reservation station with its own functional unit.
// Holds one issued instruction, snoops the CDB for pending operands,
// executes for EXEC_LATENCY cycles, then holds Done/Q until its own tag
// is broadcast back on the CDB (the arbiter's grant).
module reservation_station_add #(
   parameter logic [2:0] STATION_ID   = 3'd1,
   parameter int         EXEC_LATENCY = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Issue_Valid,
   input  logic        Issue_Op,
   input  logic [15:0] Issue_Vj,
   input  logic [2:0]  Issue_Qj,
   input  logic [15:0] Issue_Vk,
   input  logic [2:0]  Issue_Qk,
   input  logic        CDB_Valid,
   input  logic [2:0]  Qi_CDB,
   input  logic [15:0] Qi_CDB_data,
   output logic        Busy,
   output logic        Done,
   output logic [15:0] Q
);

   typedef enum logic [1:0] {FREE, WAIT_OPS, EXEC, WRITEBACK} state_t;

   localparam logic [3:0] LAT_M1 = 4'(EXEC_LATENCY - 1);

   state_t      state;
   logic        op;
   logic [15:0] vj, vk;
   logic [2:0]  qj, qk;
   logic [3:0]  cnt;
   logic        busy_r, done_r;
   logic [15:0] q_r;

   logic [15:0] src_vj, src_vk, nxt_vj, nxt_vk, result;
   logic [2:0]  src_qj, src_qk, nxt_qj, nxt_qk;
   logic        hit_j, hit_k, grant;

   // Operand resolution: in FREE the issue fields are snooped (same-cycle
   // bypass), otherwise the stored tags are. Tag 0 never matches.
   always_comb begin
      src_vj = (state == FREE) ? Issue_Vj : vj;
      src_qj = (state == FREE) ? Issue_Qj : qj;
      src_vk = (state == FREE) ? Issue_Vk : vk;
      src_qk = (state == FREE) ? Issue_Qk : qk;
      hit_j  = CDB_Valid && (Qi_CDB != 3'd0) && (Qi_CDB == src_qj);
      hit_k  = CDB_Valid && (Qi_CDB != 3'd0) && (Qi_CDB == src_qk);
      nxt_vj = hit_j ? Qi_CDB_data : src_vj;
      nxt_qj = hit_j ? 3'd0 : src_qj;
      nxt_vk = hit_k ? Qi_CDB_data : src_vk;
      nxt_qk = hit_k ? 3'd0 : src_qk;
      grant  = CDB_Valid && (Qi_CDB == STATION_ID);
      result = op ? (vj - vk) : (vj + vk);
   end

   // Station state machine; Busy/Done/Q are registered.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state  <= FREE;
         op     <= 1'b0;
         vj     <= '0;
         vk     <= '0;
         qj     <= '0;
         qk     <= '0;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         q_r    <= '0;
      end else begin
         case (state)
            FREE: begin
               if (Issue_Valid) begin
                  op     <= Issue_Op;
                  vj     <= nxt_vj;
                  qj     <= nxt_qj;
                  vk     <= nxt_vk;
                  qk     <= nxt_qk;
                  busy_r <= 1'b1;
                  if (nxt_qj == 3'd0 && nxt_qk == 3'd0) begin
                     state <= EXEC;
                     cnt   <= LAT_M1;
                  end else begin
                     state <= WAIT_OPS;
                  end
               end
            end
            WAIT_OPS: begin
               vj <= nxt_vj;
               qj <= nxt_qj;
               vk <= nxt_vk;
               qk <= nxt_qk;
               if (nxt_qj == 3'd0 && nxt_qk == 3'd0) begin
                  state <= EXEC;
                  cnt   <= LAT_M1;
               end
            end
            EXEC: begin
               if (cnt == 4'd0) begin
                  q_r    <= result;
                  done_r <= 1'b1;
                  state  <= WRITEBACK;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            WRITEBACK: begin
               // Q is deliberately left alone on release.
               if (grant) begin
                  done_r <= 1'b0;
                  busy_r <= 1'b0;
                  state  <= FREE;
               end
            end
            default: state <= FREE;
         endcase
      end
   end

   assign Busy = busy_r;
   assign Done = done_r;
   assign Q    = q_r;

endmodule

// File: tb/tb_reservation_station_add.sv
// Bench for reservation_station_add: directed test-plan scenarios followed
// by random traffic, all checked against a timestamp-based transaction model.
module tb_reservation_station_add;

   localparam logic [2:0] ID  = 3'd1;
   localparam int         LAT = 2;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Issue_Valid, Issue_Op;
   logic [15:0] Issue_Vj, Issue_Vk;
   logic [2:0]  Issue_Qj, Issue_Qk;
   logic        CDB_Valid;
   logic [2:0]  Qi_CDB;
   logic [15:0] Qi_CDB_data;
   logic        Busy, Done;
   logic [15:0] Q;

   int checks = 0;
   int fails  = 0;

   // Reference model: one instruction record plus the edge index at which
   // it became ready; completion is readiness time + LAT.
   bit          m_busy, m_done, m_op;
   logic [15:0] m_q, m_vj, m_vk;
   logic [2:0]  m_qj, m_qk;
   int          m_ready_at;
   int          edge_no = 0;

   reservation_station_add #(.STATION_ID(ID), .EXEC_LATENCY(LAT)) dut (
      .Clock(Clock), .Reset(Reset),
      .Issue_Valid(Issue_Valid), .Issue_Op(Issue_Op),
      .Issue_Vj(Issue_Vj), .Issue_Qj(Issue_Qj),
      .Issue_Vk(Issue_Vk), .Issue_Qk(Issue_Qk),
      .CDB_Valid(CDB_Valid), .Qi_CDB(Qi_CDB), .Qi_CDB_data(Qi_CDB_data),
      .Busy(Busy), .Done(Done), .Q(Q)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h (edge %0d)", tag, act, exp, edge_no);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_op = 0; m_q = '0;
      m_vj = '0; m_vk = '0; m_qj = '0; m_qk = '0; m_ready_at = -1;
   endtask

   function automatic bit hit(input logic [2:0] t);
      return CDB_Valid && t != 3'd0 && Qi_CDB == t;
   endfunction

   // Advance the model by one edge using the currently driven inputs.
   task automatic model_edge();
      if (!m_busy) begin
         if (Issue_Valid) begin
            m_busy = 1; m_op = Issue_Op;
            m_vj = Issue_Vj; m_qj = Issue_Qj; m_vk = Issue_Vk; m_qk = Issue_Qk;
            if (hit(m_qj)) begin m_vj = Qi_CDB_data; m_qj = 0; end
            if (hit(m_qk)) begin m_vk = Qi_CDB_data; m_qk = 0; end
            m_ready_at = (m_qj == 0 && m_qk == 0) ? edge_no : -1;
         end
      end else if (m_done) begin
         if (CDB_Valid && Qi_CDB == ID) begin m_busy = 0; m_done = 0; end
      end else if (m_ready_at < 0) begin
         logic [15:0] d;
         d = Qi_CDB_data;
         if (hit(m_qj)) begin m_vj = d; m_qj = 0; end
         if (hit(m_qk)) begin m_vk = d; m_qk = 0; end
         if (m_qj == 0 && m_qk == 0) m_ready_at = edge_no;
      end else if (edge_no == m_ready_at + LAT) begin
         m_done = 1;
         m_q = m_op ? m_vj - m_vk : m_vj + m_vk;
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare.
   task automatic step(input bit iv, input bit op, input logic [15:0] vj, input logic [2:0] qj,
                       input logic [15:0] vk, input logic [2:0] qk,
                       input bit cv, input logic [2:0] qi, input logic [15:0] cd);
      Issue_Valid = iv; Issue_Op = op; Issue_Vj = vj; Issue_Qj = qj;
      Issue_Vk = vk; Issue_Qk = qk; CDB_Valid = cv; Qi_CDB = qi; Qi_CDB_data = cd;
      if (iv) assert (qj != ID && qk != ID);
      model_edge();
      @(posedge Clock);
      @(negedge Clock);
      chk("busy", {15'd0, Busy}, {15'd0, m_busy});
      chk("done", {15'd0, Done}, {15'd0, m_done});
      chk("q", Q, m_q);
      edge_no++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic grant_self();
      step(0, 0, 0, 0, 0, 0, 1, ID, 16'h1234);
   endtask

   initial begin
      Reset = 1'b0;
      Issue_Valid = 0; Issue_Op = 0; Issue_Vj = 0; Issue_Qj = 0;
      Issue_Vk = 0; Issue_Qk = 0; CDB_Valid = 0; Qi_CDB = 0; Qi_CDB_data = 0;
      model_reset();
      @(negedge Clock);
      chk("rst_busy", {15'd0, Busy}, 16'd0);
      chk("rst_done", {15'd0, Done}, 16'd0);
      chk("rst_q", Q, 16'd0);
      Reset = 1'b1;

      // Ready issue: 5 + 7
      step(1, 0, 16'd5, 0, 16'd7, 0, 0, 0, 0);
      chk("tp1_busy", {15'd0, Busy}, 16'd1);
      idle(1);
      chk("tp1_notyet", {15'd0, Done}, 16'd0);
      idle(1);
      chk("tp1_q", Q, 16'd12);
      chk("tp1_done", {15'd0, Done}, 16'd1);
      idle(1);
      grant_self();
      chk("tp1_free", {15'd0, Busy}, 16'd0);

      // Pending j operand, second issue ignored, foreign tag ignored: 10 - 3
      step(1, 1, 16'hAAAA, 2, 16'd3, 0, 0, 0, 0);
      idle(3);
      step(1, 0, 16'd100, 0, 16'd200, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 3, 16'd99);
      chk("tp2_wait", {15'd0, Done}, 16'd0);
      step(0, 0, 0, 0, 0, 0, 1, 2, 16'd10);
      idle(LAT);
      chk("tp2_q", Q, 16'd7);
      // Foreign grant in writeback
      step(0, 0, 0, 0, 0, 0, 1, 2, 16'd55);
      chk("tp2_hold_done", {15'd0, Done}, 16'd1);
      chk("tp2_hold_q", Q, 16'd7);
      grant_self();

      // Wrap with issue bypass: 0 - 1
      step(1, 1, 16'd0, 0, 16'd77, 2, 1, 2, 16'd1);
      idle(LAT);
      chk("tp3_q", Q, 16'hFFFF);
      grant_self();

      // Both operands on one tag: 8000 + 8000, foreign tag 3 first
      step(1, 0, 16'd1, 2, 16'd1, 2, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 3, 16'h4000);
      step(0, 0, 0, 0, 0, 0, 1, 2, 16'h8000);
      idle(LAT);
      chk("tp4_q", Q, 16'h0000);
      chk("tp4_done", {15'd0, Done}, 16'd1);
      grant_self();

      // Async reset during EXEC, then a normal instruction
      step(1, 0, 16'd40, 0, 16'd2, 0, 0, 0, 0);
      #2 Reset = 1'b0;
      #1;
      model_reset();
      chk("tp6_busy", {15'd0, Busy}, 16'd0);
      chk("tp6_done", {15'd0, Done}, 16'd0);
      chk("tp6_q", Q, 16'd0);
      #1 Reset = 1'b1;
      step(1, 1, 16'd50, 0, 16'd8, 0, 0, 0, 0);
      idle(LAT);
      chk("tp6_q2", Q, 16'd42);
      grant_self();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] tags [4];
         tags[0] = 0; tags[1] = 0; tags[2] = 2; tags[3] = 3;
         step($urandom_range(0, 2) == 0, 1'($urandom), 16'($urandom), tags[$urandom_range(0, 3)],
              16'($urandom), tags[$urandom_range(0, 3)],
              $urandom_range(0, 1) == 1, 3'($urandom_range(0, 3)), 16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
